// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART.
// Holds the bus window base, register offsets, CON bit positions and the
// 2-bit state encoding used by both the TX and RX state machines.
package uart_pkg;

  localparam logic [31:0] UART_BASE = 32'h4000_0000;
  localparam logic [31:0] TXD_ADDR  = 32'h0000_0018;
  localparam logic [31:0] RXD_ADDR  = 32'h0000_001C;
  localparam logic [31:0] CON_ADDR  = 32'h0000_0020;

  localparam int unsigned CON_TX_IE     = 0;
  localparam int unsigned CON_RX_IE     = 1;
  localparam int unsigned CON_RX_STATUS = 2;
  localparam int unsigned CON_TX_DONE   = 3;
  localparam int unsigned CON_TX_BUSY   = 4;
  localparam int unsigned CON_FRAME_ERR = 5;
  localparam int unsigned CON_OVERRUN   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver (LSB first).
// Ports:
//   clk, reset    system clock, async active-high reset
//   rx_i          asynchronous serial input
//   data_o        last shifted-in byte (stable when byte_valid_c pulses)
//   byte_valid_c  one-cycle pulse: frame completed with a good stop bit
//   frame_err_c   one-cycle pulse: frame completed with stop bit = 0
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       byte_valid_c,
  output logic       frame_err_c
);

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  assign data_o = shift_q;

  // Synchroniser, edge-detect history and FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next state: half a bit into START re-checks the line, then every full
  // bit period lands on the middle of the next bit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid-start means it was a glitch
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) byte_valid_c = 1'b1;
          else         frame_err_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART at 0x4000_0018 (TXD), 0x1C (RXD), 0x20 (CON).
// Ports:
//   clk, reset          system clock, async active-high reset
//   rd, wr              single-cycle read / write strobes
//   addr, wdata         byte address and write data
//   rdata               combinational read data (0 when idle or unmapped)
//   RX                  asynchronous serial input
//   TX                  registered serial output
//   irqout              [0] RX level interrupt, [1] TX level interrupt
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        RX,
  output logic        TX,
  output logic [1:0]  irqout
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TXD_FULL = UART_BASE | TXD_ADDR;
  localparam logic [31:0] RXD_FULL = UART_BASE | RXD_ADDR;
  localparam logic [31:0] CON_FULL = UART_BASE | CON_ADDR;

  logic sel_txd, sel_rxd, sel_con;
  logic tx_busy, tx_accept, tx_finish_c;
  logic [7:0] rx_byte;
  logic rx_valid_c, rx_ferr_c;
  logic [31:0] con_val;
  logic unused_wdata;

  // Register file
  logic [7:0] txd_q, txd_d, rx_data_q, rx_data_d;
  logic tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d;
  logic rx_status_q, rx_status_d, tx_done_q, tx_done_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic tx_go_q, tx_go_d;

  // TX engine
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d;

  assign unused_wdata = ^wdata[31:8];

  assign sel_txd = (addr == TXD_FULL);
  assign sel_rxd = (addr == RXD_FULL);
  assign sel_con = (addr == CON_FULL);

  assign tx_busy   = (tx_state_q != IDLE);
  // A launch already pending counts as busy so a second write cannot retarget it
  assign tx_accept = wr && sel_txd && !tx_busy && !tx_go_q;

  assign con_val = {25'b0, overrun_q, frame_err_q, tx_busy, tx_done_q,
                    rx_status_q, rx_ie_q, tx_ie_q};

  assign TX     = tx_q;
  assign irqout = {tx_ie_q & tx_done_q, rx_ie_q & rx_status_q};

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (RX),
    .data_o      (rx_byte),
    .byte_valid_c(rx_valid_c),
    .frame_err_c (rx_ferr_c)
  );

  // Read mux
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'b0, txd_q};
      else if (sel_rxd) rdata = {24'b0, rx_data_q};
      else if (sel_con) rdata = con_val;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd_q       <= '0;
      rx_data_q   <= '0;
      tx_ie_q     <= 1'b0;
      rx_ie_q     <= 1'b0;
      rx_status_q <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_go_q     <= 1'b0;
      tx_state_q  <= IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
    end else begin
      txd_q       <= txd_d;
      rx_data_q   <= rx_data_d;
      tx_ie_q     <= tx_ie_d;
      rx_ie_q     <= rx_ie_d;
      rx_status_q <= rx_status_d;
      tx_done_q   <= tx_done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      tx_go_q     <= tx_go_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
    end
  end

  // TX FSM: one cycle after an accepted write, START drives the line low
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_d        = tx_q;
    tx_finish_c = 1'b0;
    case (tx_state_q)
      IDLE: begin
        if (tx_go_q) begin
          tx_state_d = START;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
          tx_d       = txd_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = txd_q[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = IDLE;
          tx_finish_c = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Register updates; hardware set events are applied last so they win
  // against same-cycle read clears.
  always_comb begin
    txd_d       = txd_q;
    rx_data_d   = rx_data_q;
    tx_ie_d     = tx_ie_q;
    rx_ie_d     = rx_ie_q;
    rx_status_d = rx_status_q;
    tx_done_d   = tx_done_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    tx_go_d     = tx_accept;

    if (tx_accept) txd_d = wdata[7:0];

    if (wr && sel_con) begin
      tx_ie_d = wdata[CON_TX_IE];
      rx_ie_d = wdata[CON_RX_IE];
      if (wdata[CON_FRAME_ERR]) frame_err_d = 1'b0;
      if (wdata[CON_OVERRUN])   overrun_d   = 1'b0;
    end

    if (rd && sel_rxd) rx_status_d = 1'b0;
    if (rd && sel_con) tx_done_d   = 1'b0;

    if (tx_finish_c) tx_done_d = 1'b1;

    if (rx_valid_c) begin
      rx_data_d   = rx_byte;
      rx_status_d = 1'b1;
      if (rx_status_q) overrun_d = 1'b1;
    end
    if (rx_ferr_c) frame_err_d = 1'b1;
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: randomized self-checking bench for uart_mmio (CLKS_PER_BIT=4).
module tb_uart_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic clk = 1'b0;
  logic reset, rd, wr, RX, TX;
  logic [31:0] addr, wdata, rdata;
  logic [1:0] irqout;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_lat   = -1;

  // Reference model of the programmer-visible state
  logic [7:0] m_txd, m_rx_data;
  logic m_tx_ie, m_rx_ie, m_rx_status, m_tx_done, m_ferr, m_ovr;

  always #5 clk = ~clk;

  uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .RX    (RX),
    .TX    (TX),
    .irqout(irqout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] con_model(input logic busy);
    return {25'b0, m_ovr, m_ferr, busy, m_tx_done, m_rx_status, m_rx_ie, m_tx_ie};
  endfunction

  task automatic model_reset();
    m_txd = '0; m_rx_data = '0; m_tx_ie = 0; m_rx_ie = 0;
    m_rx_status = 0; m_tx_done = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk); rd = 1'b0; addr = '0;
  endtask

  task automatic read_con_check(input string tag);
    logic [31:0] d;
    bus_read(A_CON, d);
    check(tag, 64'(d), 64'(con_model(1'b0)));
    m_tx_done = 1'b0;
  endtask

  task automatic read_rxd_check(input string tag);
    logic [31:0] d;
    bus_read(A_RXD, d);
    check(tag, 64'(d), 64'({24'b0, m_rx_data}));
    m_rx_status = 1'b0;
  endtask

  task automatic write_con(input logic t, input logic r, input logic cf, input logic co);
    // RO bits [4:2] written as 1 must have no effect
    bus_write(A_CON, {25'b0, co, cf, 3'b111, r, t});
    m_tx_ie = t; m_rx_ie = r;
    if (cf) m_ferr = 1'b0;
    if (co) m_ovr  = 1'b0;
  endtask

  // Send byte b; optionally attempt a second TXD write at cycle drop_at
  task automatic tx_frame(input logic [7:0] b, input int drop_at, input logic [7:0] drop_byte);
    logic [FRAME-1:0] exp_w, obs_w, exp_busy, obs_busy;
    logic [9:0] fr;
    logic [11:0] idle_w;
    logic [31:0] d;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < int'(FRAME); i++) exp_w[i] = fr[i / int'(CPB)];
    exp_busy = '0; obs_busy = '0; obs_w = '0;
    bus_write(A_TXD, {24'b0, b});
    m_txd = b;
    #1 check("tx_launch_idle", 64'(TX), 64'(1'b1));
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk);
      if (i == drop_at) begin
        rd = 1'b0; wr = 1'b1; addr = A_TXD; wdata = {24'b0, drop_byte};
      end else begin
        wr = 1'b0; rd = 1'b1; addr = A_CON; exp_busy[i] = 1'b1;
      end
      #1 obs_w[i] = TX;
      if (i != drop_at) obs_busy[i] = rdata[4];
    end
    @(negedge clk); wr = 1'b0; rd = 1'b1; addr = A_CON;
    #1 d = rdata;
    m_tx_done = 1'b1;
    check("tx_wave", 64'(obs_w), 64'(exp_w));
    check("tx_busy", 64'(obs_busy), 64'(exp_busy));
    check("tx_done_con", 64'(d), 64'(con_model(1'b0)));
    check("tx_irq_set", 64'(irqout[1]), 64'(m_tx_ie));
    @(negedge clk); rd = 1'b0; addr = '0;
    m_tx_done = 1'b0;
    #1 check("tx_irq_clr", 64'(irqout[1]), 64'(1'b0));
    for (int i = 0; i < 12; i++) begin @(negedge clk); #1 idle_w[i] = TX; end
    check("tx_idle_after", 64'(idle_w), 64'(12'hFFF));
    bus_read(A_TXD, d);
    check("txd_readback", 64'(d), 64'({24'b0, m_txd}));
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk); RX = fr[k];
      end
  endtask

  // Full frame plus settle time, then fold into the model
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx_send(b, stop);
    @(negedge clk); RX = 1'b1;
    repeat (3) @(negedge clk);
    if (stop) begin
      if (m_rx_status) m_ovr = 1'b1;
      m_rx_data = b; m_rx_status = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0] b, old_b;
    logic irq_at;
    int kc;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; RX = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check("rst_tx", 64'(TX), 64'(1'b1));
    check("rst_irq", 64'(irqout), 64'(2'b00));
    @(negedge clk); reset = 1'b0;
    read_con_check("rst_con");
    read_rxd_check("rst_rxd");
    bus_read(A_TXD, d); check("rst_txd", 64'(d), 64'(0));

    // Decode corner cases
    bus_read(32'h4000_0024, d); check("unmapped_rd", 64'(d), 64'(0));
    bus_read(32'h4000_0019, d); check("misaligned_rd", 64'(d), 64'(0));
    @(negedge clk); addr = A_CON; #1 check("rd_low_zero", 64'(rdata), 64'(0));
    bus_write(32'h4000_0014, 32'hFFFF_FFFF);
    read_con_check("unmapped_wr");

    // Transmit
    write_con(1'b1, 1'b1, 1'b0, 1'b0);
    tx_frame(8'h55, -1, 8'h00);
    for (int n = 0; n < 3; n++) begin
      write_con(1'($urandom % 2), 1'b1, 1'b0, 1'b0);
      tx_frame(8'($urandom), -1, 8'h00);
    end
    write_con(1'b1, 1'b1, 1'b0, 1'b0);
    tx_frame(8'hA3, 13, 8'h0F);
    tx_frame(8'($urandom), int'($urandom_range(1, 30)), 8'($urandom));

    // Receive 0xC4 while measuring the completion latency
    fork
      rx_send(8'hC4, 1'b1);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          #1 if (irqout[0] && rx_lat < 0) rx_lat = k;
        end
      end
    join
    m_rx_data = 8'hC4; m_rx_status = 1'b1;
    check("rx_latency_in_window", 64'(rx_lat >= 40 && rx_lat <= 42), 64'(1));
    check("rx_irq_set", 64'(irqout[0]), 64'(1'b1));
    read_rxd_check("rx_c4");
    #1 check("rx_irq_clr", 64'(irqout[0]), 64'(1'b0));
    read_con_check("rx_status_clr");

    // Random frames with random reads in between
    for (int n = 0; n < 4; n++) begin
      rx_frame(8'($urandom), 1'b1);
      read_con_check("rx_rand_con");
      if ($urandom % 2) read_rxd_check("rx_rand_rxd");
    end
    write_con(1'b1, 1'b1, 1'b1, 1'b1);
    read_rxd_check("rx_prep");

    // 1-cycle glitch must not produce a byte
    @(negedge clk); RX = 1'b0;
    @(negedge clk); RX = 1'b1;
    repeat (45) @(negedge clk);
    read_con_check("glitch_con");
    #1 check("glitch_irq", 64'(irqout[0]), 64'(1'b0));

    // Bad stop bit with a pending byte: byte kept, frame_err set
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'h81, 1'b0);
    read_con_check("ferr_con");
    read_rxd_check("ferr_rxd_kept");
    write_con(1'b1, 1'b1, 1'b1, 1'b0);
    read_con_check("ferr_clr");

    // Back-to-back frames without a read: overrun, second byte wins
    b = 8'($urandom);
    rx_send(8'($urandom), 1'b1);
    rx_frame(b, 1'b1);
    m_ovr = 1'b1;
    read_con_check("ovr_con");
    read_rxd_check("ovr_rxd_second");
    write_con(1'b1, 1'b1, 1'b0, 1'b1);
    read_con_check("ovr_clr");

    // RXD read in the cycle the next byte completes
    old_b = m_rx_data;
    b = 8'($urandom);
    kc = (rx_lat > 0) ? rx_lat : 41;
    fork
      rx_send(b, 1'b1);
      begin
        repeat (kc) @(negedge clk);
        rd = 1'b1; addr = A_RXD;
        #1 d = rdata;
        @(negedge clk); rd = 1'b0; addr = '0;
        #1 irq_at = irqout[0];
      end
    join
    repeat (2) @(negedge clk);
    check("coll_old_byte", 64'(d), 64'({24'b0, old_b}));
    check("coll_irq", 64'(irq_at), 64'(1'b1));
    m_rx_data = b; m_rx_status = 1'b1;
    read_con_check("coll_con");
    read_rxd_check("coll_new_byte");
    rx_frame(8'($urandom), 1'b1);

    // Reset in the middle of a transmission
    bus_write(A_TXD, 32'h0000_0000);
    repeat (9) @(negedge clk);
    #1 check("pre_rst_tx_low", 64'(TX), 64'(1'b0));
    #2 reset = 1'b1;
    #1 check("mid_rst_tx", 64'(TX), 64'(1'b1));
    check("mid_rst_irq", 64'(irqout), 64'(2'b00));
    @(negedge clk); reset = 1'b0;
    model_reset();
    read_con_check("post_rst_con");
    read_rxd_check("post_rst_rxd");
    bus_read(A_TXD, d); check("post_rst_txd", 64'(d), 64'(0));
    #1 check("post_rst_tx", 64'(TX), 64'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART responder on the processor's peripheral bus; it answers CPU loads and stores in the 0x4000_0018–0x4000_0020 window. It serialises bytes written to TXD onto `TX` and deserialises frames from `RX` into RXD. It raises level interrupts on `irqout`, which the CPU maps to its ILLRX and ILLTX trap vectors. Frame format is 8N1, LSB first.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `clk`  in  1  system clock, one domain.
- `reset`  in  1  asynchronous, active-high.
- `rd`  in  1  read strobe; one clk cycle per access.
- `wr`  in  1  write strobe; one clk cycle per access.
- `addr`  in  32  byte address; only word-aligned 0x4000_0018/1C/20 decoded.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational.
- `RX`  in  1  serial input, asynchronous.
- `TX`  out  1  serial output, registered.
- `irqout`  out  2  [0] RX interrupt, [1] TX interrupt; level.

## Operation
- Register map:
  - 0x18 TXD: write [7:0] starts a transmission. Read returns {24'b0, last written byte}.
  - 0x1C RXD: read returns {24'b0, rx_data}. The read clears rx_status.
  - 0x20 CON: bit[0] tx_ie (R/W), [1] rx_ie (R/W), [2] rx_status (RO), [3] tx_done (RO, cleared by a CON read), [4] tx_busy (RO), [5] frame_err (RO sticky), [6] overrun (RO sticky). A CON write updates [1:0]; writing 1 to [5] or [6] clears that bit.
- `rdata` = 0 when `rd`=0 or the address is unmapped. Unmapped writes are ignored.
- TX FSM: IDLE → START → DATA(8 bits) → STOP → IDLE.
  - A TXD write while tx_busy=1 is dropped silently; no state change.
  - tx_done is set on STOP → IDLE.
- RX path: 2-flop synchroniser, then FSM IDLE → START → DATA → STOP.
  - A falling edge in IDLE enters START.
  - At CLKS_PER_BIT/2 the start bit is re-sampled. If it is high (glitch), return to IDLE.
  - Data bits are sampled at mid-bit, LSB first.
  - Stop bit = 1: latch rx_data and set rx_status. If rx_status was already 1, also set overrun; the new byte overwrites.
  - Stop bit = 0: discard the byte and set frame_err.
- `irqout[0]` = rx_ie & rx_status. `irqout[1]` = tx_ie & tx_done.
- Simultaneous events:
  - RXD read in the same cycle as a byte completes: set wins, rx_status stays 1, and rdata returns the old byte.
  - CON read in the same cycle as tx_done sets: set wins.

## Timing
- Reset values: `TX`=1, `irqout`=0, CON=0, rx_data=0, TXD=0, both FSMs IDLE.
- Reset mid-frame aborts immediately: `TX` returns to 1 asynchronously and the partial RX byte is discarded.
- Reads: zero latency. `rdata` is valid in the same cycle as `rd`. Side effects apply at the rising clk edge that ends the `rd` cycle.
- TX: a TXD write sampled at edge N drives `TX` low from edge N+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx_busy is 1 from edge N+1 to edge N+1+10·CLKS_PER_BIT; tx_done is set at that same edge.
- RX:
  - rx_status sets 2 (sync) + 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the `RX` falling edge, ±1 cycle.
  - After a stop bit the receiver is ready for a new start bit immediately, so back-to-back frames are supported.

## Structure
- Package `uart_pkg`:
  - address offsets TXD_ADDR, RXD_ADDR, CON_ADDR
  - CON bit indices
  - shared 2-bit FSM state encoding IDLE/START/DATA/STOP
- One sub-module, `uart_rx_core`: synchroniser, RX FSM, baud counter, and a byte_valid / frame_err pulse output.
- The TX FSM, register file and decode stay in `uart_mmio`.

## Test plan
- **Reset:** assert `reset` mid-TX → `TX`=1, `irqout`=0, CON read = 0.
- **TX frame:** with CLKS_PER_BIT=4, write 0x55 to 0x4000_0018 → `TX` shows 0,1,0,1,0,1,0,1,0,1 at 4 cycles each. CON[4]=1 throughout, then CON[3]=1. With tx_ie=1, `irqout[1]`=1; a CON read clears it.
- **Dropped TX write:** write 0xA3, then 0x0F while busy → only the 0xA3 frame appears on `TX`.
- **RX frame:** drive the 0xC4 frame with rx_ie=1 → `irqout[0]`=1 and RXD reads 0x000000C4. After that read, CON[2]=0 and `irqout[0]`=0.
- **RX errors:**
  - A 1-cycle low glitch on `RX` → no byte received.
  - A frame with stop bit 0 → CON[5]=1 and rx_status unchanged.
  - Two frames with no RXD read in between → CON[6]=1 and RXD holds the second byte.
- **Collision:** an RXD read in the exact cycle a byte completes → rdata is the old byte and rx_status stays 1.
